// File: rtl/fir_filter_bank.sv
// Multi-band FIR bank: one shared delay line, one serial MAC per band, run-time loadable
// coefficients, round-half-up output with saturation and per-band overflow flags.
module fir_filter_bank #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned FRAC  = 15,
    parameter int unsigned TAPS  = 8,
    parameter int unsigned BANDS = 3,
    localparam int unsigned TW   = $clog2(TAPS),
    localparam int unsigned BW   = (BANDS > 1) ? $clog2(BANDS) : 1
) (
    input  logic                   clock44k,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       uk,
    input  logic                   coef_we,
    input  logic [BW-1:0]          coef_band,
    input  logic [TW-1:0]          coef_tap,
    input  logic [WIDTH-1:0]       coef_data,
    output logic [BANDS*WIDTH-1:0] yk,
    output logic                   valid,
    output logic                   busy,
    output logic [BANDS-1:0]       ovf,
    output logic                   sample_drop,
    output logic                   coef_err
);

    localparam int unsigned AW = 2*WIDTH + TW;

    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(64'd1 << FRAC);
    localparam logic signed [AW-1:0]    HALF = AW'(64'd1 << (FRAC-1));
    localparam logic signed [AW-1:0]    MAXV = AW'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic signed [AW-1:0]    MINV = -MAXV - AW'(1);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_t;

    state_t state_q, state_d;

    logic                    enable_q;
    logic                    start;
    logic [TW-1:0]           tap_q;
    logic signed [WIDTH-1:0] x_q    [TAPS];
    logic signed [WIDTH-1:0] coef_q [BANDS][TAPS];
    logic signed [AW-1:0]    acc_q  [BANDS];

    logic signed [2*WIDTH-1:0] prod    [BANDS];
    logic signed [AW-1:0]      shifted [BANDS];
    logic signed [WIDTH-1:0]   sat_val [BANDS];
    logic [BANDS-1:0]          sat_hit;
    logic                      coef_ok;

    assign start   = enable & ~enable_q;
    assign coef_ok = (32'(coef_band) < BANDS) && (32'(coef_tap) < TAPS);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StMac;
            StMac:   if (tap_q == TW'(TAPS-1)) state_d = StOut;
            // OUT spans two cycles: compute, then the valid cycle
            StOut:   if (valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock44k or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        sat_hit = '0;
        for (int b = 0; b < BANDS; b++) begin
            prod[b]    = coef_q[b][tap_q] * x_q[tap_q];
            shifted[b] = (acc_q[b] + HALF) >>> FRAC;
            sat_val[b] = shifted[b][WIDTH-1:0];
            if (shifted[b] > MAXV) begin
                sat_val[b] = MAXV[WIDTH-1:0];
                sat_hit[b] = 1'b1;
            end else if (shifted[b] < MINV) begin
                sat_val[b] = MINV[WIDTH-1:0];
                sat_hit[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock44k or posedge reset) begin
        if (reset) begin
            enable_q    <= 1'b0;
            tap_q       <= '0;
            yk          <= '0;
            ovf         <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            sample_drop <= 1'b0;
            coef_err    <= 1'b0;
            for (int t = 0; t < TAPS; t++) x_q[t] <= '0;
            for (int b = 0; b < BANDS; b++) begin
                acc_q[b] <= '0;
                for (int t = 0; t < TAPS; t++) coef_q[b][t] <= (t == 0) ? ONE : '0;
            end
        end else begin
            enable_q    <= enable;
            sample_drop <= start && (state_q != StIdle);
            coef_err    <= coef_we && (state_q != StIdle);

            if (coef_we && coef_ok && (state_q == StIdle)) begin
                coef_q[coef_band][coef_tap] <= coef_data;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        x_q[0] <= uk;
                        for (int t = 1; t < TAPS; t++) x_q[t] <= x_q[t-1];
                        for (int b = 0; b < BANDS; b++) acc_q[b] <= '0;
                        tap_q <= '0;
                        busy  <= 1'b1;
                    end
                end
                StMac: begin
                    for (int b = 0; b < BANDS; b++) begin
                        acc_q[b] <= acc_q[b] + {{TW{prod[b][2*WIDTH-1]}}, prod[b]};
                    end
                    tap_q <= tap_q + TW'(1);
                end
                StOut: begin
                    if (!valid) begin
                        for (int b = 0; b < BANDS; b++) yk[b*WIDTH +: WIDTH] <= sat_val[b];
                        ovf   <= sat_hit;
                        valid <= 1'b1;
                    end else begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
